// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - tap-mask tables, mode encodings and next-state function for lfsr_gen
package lfsr_pkg;

    localparam int MODE_FIBONACCI = 0;
    localparam int MODE_GALOIS    = 1;
    localparam int MIN_WIDTH      = 3;
    localparam int MAX_WIDTH      = 32;

    // Fibonacci masks: bit (t-1) set for each tap t of a maximal-length polynomial
    function automatic logic [31:0] fib_mask(input int w);
        logic [31:0] m;
        case (w)
            3:       m = 32'h0000_0006;
            4:       m = 32'h0000_000C;
            5:       m = 32'h0000_0014;
            6:       m = 32'h0000_0030;
            7:       m = 32'h0000_0060;
            8:       m = 32'h0000_00B8;
            9:       m = 32'h0000_0110;
            10:      m = 32'h0000_0240;
            11:      m = 32'h0000_0500;
            12:      m = 32'h0000_0829;
            13:      m = 32'h0000_100D;
            14:      m = 32'h0000_2015;
            15:      m = 32'h0000_6000;
            16:      m = 32'h0000_D008;
            17:      m = 32'h0001_2000;
            18:      m = 32'h0002_0400;
            19:      m = 32'h0004_0023;
            20:      m = 32'h0009_0000;
            21:      m = 32'h0014_0000;
            22:      m = 32'h0030_0000;
            23:      m = 32'h0042_0000;
            24:      m = 32'h00E1_0000;
            25:      m = 32'h0120_0000;
            26:      m = 32'h0200_0023;
            27:      m = 32'h0400_0013;
            28:      m = 32'h0900_0000;
            29:      m = 32'h1400_0000;
            30:      m = 32'h2000_0029;
            31:      m = 32'h4800_0000;
            32:      m = 32'h8020_0003;
            default: m = 32'h0000_0000;
        endcase
        return m;
    endfunction

    // Galois masks: the same polynomials with the x^W term dropped and the +1 term kept
    function automatic logic [31:0] galois_mask(input int w);
        logic [31:0] m;
        case (w)
            3:       m = 32'h0000_0005;
            4:       m = 32'h0000_0009;
            5:       m = 32'h0000_0009;
            6:       m = 32'h0000_0021;
            7:       m = 32'h0000_0041;
            8:       m = 32'h0000_0071;
            9:       m = 32'h0000_0021;
            10:      m = 32'h0000_0081;
            11:      m = 32'h0000_0201;
            12:      m = 32'h0000_0053;
            13:      m = 32'h0000_001B;
            14:      m = 32'h0000_002B;
            15:      m = 32'h0000_4001;
            16:      m = 32'h0000_A011;
            17:      m = 32'h0000_4001;
            18:      m = 32'h0000_0801;
            19:      m = 32'h0000_0047;
            20:      m = 32'h0002_0001;
            21:      m = 32'h0008_0001;
            22:      m = 32'h0020_0001;
            23:      m = 32'h0004_0001;
            24:      m = 32'h00C2_0001;
            25:      m = 32'h0040_0001;
            26:      m = 32'h0000_0047;
            27:      m = 32'h0000_0027;
            28:      m = 32'h0200_0001;
            29:      m = 32'h0800_0001;
            30:      m = 32'h0000_0053;
            31:      m = 32'h1000_0001;
            32:      m = 32'h0040_0007;
            default: m = 32'h0000_0000;
        endcase
        return m;
    endfunction

    // One LFSR step on a right-aligned state of width w; bits above w are cleared
    function automatic logic [31:0] lfsr_step(input logic [31:0] s, input int w, input int mode);
        logic [31:0] wmask;
        logic [31:0] nxt;
        logic        msb;
        wmask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        msb   = |(s & (32'd1 << (w - 1)));
        if (mode == MODE_GALOIS) begin
            nxt = {s[30:0], 1'b0} ^ (msb ? galois_mask(w) : 32'd0);
        end else begin
            nxt = {s[30:0], ^(s & fib_mask(w))};
        end
        return nxt & wmask;
    endfunction

endpackage

// File: rtl/lfsr_next.sv
// rtl/lfsr_next.sv - combinational next-state logic for one LFSR step
module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int MODE  = MODE_FIBONACCI
) (
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] nxt
);

    // Widen to the package's 32-bit working width, step, then trim back
    always_comb begin
        nxt = WIDTH'(lfsr_step(32'(cur), WIDTH, MODE));
    end

endmodule

// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - maximal-length LFSR with load, lockup guard and period-wrap pulse
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter int               MODE  = MODE_FIBONACCI,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] lfsr,
    output logic             bit_out,
    output logic             wrap,
    output logic             lockup
);

    // Reject configurations that cannot produce a maximal-length sequence
    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("lfsr_gen: WIDTH must be in 3..32");
    end
    if (MODE != MODE_FIBONACCI && MODE != MODE_GALOIS) begin : g_bad_mode
        $error("lfsr_gen: MODE must be 0 (Fibonacci) or 1 (Galois)");
    end
    if (SEED == '0) begin : g_bad_seed
        $error("lfsr_gen: SEED must be nonzero");
    end

    // State the sequence started from; seeing it again means one full period elapsed
    logic [WIDTH-1:0] ref_state;
    logic [WIDTH-1:0] step_value;

    lfsr_next #(
        .WIDTH (WIDTH),
        .MODE  (MODE)
    ) u_next (
        .cur (lfsr),
        .nxt (step_value)
    );

    assign bit_out = lfsr[WIDTH-1];

    // Load beats step beats hold; a zero load is replaced by SEED so the register never locks up
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr      <= SEED;
            ref_state <= SEED;
            wrap      <= 1'b0;
            lockup    <= 1'b0;
        end else if (load) begin
            wrap <= 1'b0;
            if (seed_in != '0) begin
                lfsr      <= seed_in;
                ref_state <= seed_in;
                lockup    <= 1'b0;
            end else begin
                lfsr      <= SEED;
                ref_state <= SEED;
                lockup    <= 1'b1;
            end
        end else if (enable) begin
            lfsr   <= step_value;
            wrap   <= (step_value == ref_state);
            lockup <= 1'b0;
        end else begin
            wrap   <= 1'b0;
            lockup <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lfsr_gen.sv
// tb/tb_lfsr_gen.sv - self-checking bench for lfsr_gen
module tb_lfsr_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        en16, ld16, en4, ld4, en8;
    logic [15:0] sd16;
    logic [3:0]  sd4;
    logic [15:0] lfsr16;
    logic [3:0]  lfsr4;
    logic [7:0]  lfsr8g, lfsr8f;
    logic        bo16, bo4, bo8g, bo8f;
    logic        wrap16, wrap4, wrap8g, wrap8f;
    logic        lock16, lock4, lock8g, lock8f;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    lfsr_gen #(.WIDTH(16), .MODE(0), .SEED(16'h0001)) u16 (
        .clk(clk), .reset(reset), .enable(en16), .load(ld16), .seed_in(sd16),
        .lfsr(lfsr16), .bit_out(bo16), .wrap(wrap16), .lockup(lock16));
    lfsr_gen #(.WIDTH(4), .MODE(0), .SEED(4'h1)) u4 (
        .clk(clk), .reset(reset), .enable(en4), .load(ld4), .seed_in(sd4),
        .lfsr(lfsr4), .bit_out(bo4), .wrap(wrap4), .lockup(lock4));
    lfsr_gen #(.WIDTH(8), .MODE(1), .SEED(8'h01)) u8g (
        .clk(clk), .reset(reset), .enable(en8), .load(1'b0), .seed_in(8'h00),
        .lfsr(lfsr8g), .bit_out(bo8g), .wrap(wrap8g), .lockup(lock8g));
    lfsr_gen #(.WIDTH(8), .MODE(0), .SEED(8'h01)) u8f (
        .clk(clk), .reset(reset), .enable(en8), .load(1'b0), .seed_in(8'h00),
        .lfsr(lfsr8f), .bit_out(bo8f), .wrap(wrap8f), .lockup(lock8f));

    typedef struct {
        logic        ld;
        logic        en;
        logic [15:0] seed;
        logic [15:0] exp_lfsr;
        logic        exp_wrap;
        logic        exp_lock;
    } vec_t;

    vec_t        tbl[10];
    logic [3:0]  exp4[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Polynomial-level reference: taps listed as exponents of the feedback polynomial
    function automatic logic [31:0] model_step(input logic [31:0] s, input int w, input bit galois);
        int          taps[$];
        logic [31:0] mask;
        logic [31:0] n;
        bit          fb;
        mask = (32'd1 << w) - 32'd1;
        case (w)
            4:       taps = '{4, 3};
            8:       taps = '{8, 6, 5, 4};
            default: taps = '{16, 15, 13, 4};
        endcase
        if (!galois) begin
            fb = 1'b0;
            foreach (taps[i]) fb ^= (((s >> (taps[i] - 1)) & 32'd1) != 32'd0);
            n = ((s << 1) | 32'(fb)) & mask;
        end else begin
            n = (s << 1) & mask;
            if (((s >> (w - 1)) & 32'd1) != 32'd0) begin
                n ^= 32'd1;
                foreach (taps[i]) if (taps[i] < w) n ^= (32'd1 << taps[i]);
            end
        end
        return n;
    endfunction

    // Random-phase model state: value and number of steps since the last anchor
    logic [31:0] m16, m4, mg, mf;
    int          c16, c4;
    logic        ew16, el16, ew4, el4;
    bit          seen_g[256];
    bit          seen_f[256];
    int          dist_g, dist_f, wraps_g, wraps_f;
    logic        r_ld16, r_en16, r_ld4, r_en4;
    logic [15:0] r_sd16;
    logic [3:0]  r_sd4;

    initial begin
        tbl[0] = '{1'b0, 1'b1, 16'h0000, 16'h0002, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 16'h0000, 16'h0004, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 16'h0000, 16'h0008, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 16'h0000, 16'h0011, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 16'h0000, 16'h0011, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 16'hACE1, 16'hACE1, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 16'h0000, 16'h59C3, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 16'h0000, 16'h0001, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 1'b0, 16'h0000, 16'h0001, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 1'b1, 16'h0000, 16'h0002, 1'b0, 1'b0};
        exp4 = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5,
                 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};

        reset = 1'b1;
        en16 = 1'b0; ld16 = 1'b0; sd16 = '0;
        en4 = 1'b0;  ld4 = 1'b0;  sd4 = '0;
        en8 = 1'b0;
        repeat (2) tick();
        check("reset_lfsr16", 32'(lfsr16), 32'h1);
        check("reset_wrap16", 32'(wrap16), 32'h0);
        check("reset_lock16", 32'(lock16), 32'h0);
        check("reset_lfsr4", 32'(lfsr4), 32'h1);
        check("reset_lfsr8g", 32'(lfsr8g), 32'h1);
        reset = 1'b0;

        // Table: basic steps, hold, load-over-enable, zero-load recovery
        for (int i = 0; i < 10; i++) begin
            ld16 = tbl[i].ld; en16 = tbl[i].en; sd16 = tbl[i].seed;
            tick();
            check($sformatf("tbl%0d_lfsr", i), 32'(lfsr16), 32'(tbl[i].exp_lfsr));
            check($sformatf("tbl%0d_bit", i), 32'(bo16), 32'(tbl[i].exp_lfsr[15]));
            check($sformatf("tbl%0d_wrap", i), 32'(wrap16), 32'(tbl[i].exp_wrap));
            check($sformatf("tbl%0d_lock", i), 32'(lock16), 32'(tbl[i].exp_lock));
        end
        ld16 = 1'b0; en16 = 1'b0;

        // 4-bit full period with wrap on the 15th step, then freeze
        en4 = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            check($sformatf("w4_step%0d", i + 1), 32'(lfsr4), 32'(exp4[i]));
            check($sformatf("w4_bit%0d", i + 1), 32'(bo4), 32'(exp4[i][3]));
            check($sformatf("w4_wrap%0d", i + 1), 32'(wrap4), 32'(i == 14));
        end
        en4 = 1'b0;
        tick();
        check("w4_hold_lfsr", 32'(lfsr4), 32'h1);
        check("w4_hold_wrap", 32'(wrap4), 32'h0);

        // 8-bit Galois and Fibonacci full periods
        mg = 32'h1; mf = 32'h1; dist_g = 0; dist_f = 0; wraps_g = 0; wraps_f = 0;
        en8 = 1'b1;
        for (int c = 1; c <= 255; c++) begin
            tick();
            mg = model_step(mg, 8, 1'b1);
            mf = model_step(mf, 8, 1'b0);
            check($sformatf("g8_step%0d", c), 32'(lfsr8g), mg);
            check($sformatf("f8_step%0d", c), 32'(lfsr8f), mf);
            check($sformatf("g8_bit%0d", c), 32'(bo8g), 32'(mg[7]));
            check($sformatf("f8_bit%0d", c), 32'(bo8f), 32'(mf[7]));
            check($sformatf("g8_wrap%0d", c), 32'(wrap8g), 32'(c == 255));
            check($sformatf("f8_wrap%0d", c), 32'(wrap8f), 32'(c == 255));
            if (lfsr8g != 8'h00 && !seen_g[lfsr8g]) begin seen_g[lfsr8g] = 1'b1; dist_g++; end
            if (lfsr8f != 8'h00 && !seen_f[lfsr8f]) begin seen_f[lfsr8f] = 1'b1; dist_f++; end
            if (wrap8g) wraps_g++;
            if (wrap8f) wraps_f++;
        end
        en8 = 1'b0;
        check("g8_distinct", 32'(dist_g), 32'd255);
        check("f8_distinct", 32'(dist_f), 32'd255);
        check("g8_wrap_count", 32'(wraps_g), 32'd1);
        check("f8_wrap_count", 32'(wraps_f), 32'd1);

        // Zero load then 100 steps: never the all-zero state
        ld16 = 1'b1; sd16 = 16'h0000;
        tick();
        check("zload_lfsr", 32'(lfsr16), 32'h1);
        check("zload_lock", 32'(lock16), 32'h1);
        ld16 = 1'b0; en16 = 1'b1;
        m16 = 32'h1;
        for (int c = 1; c <= 100; c++) begin
            tick();
            m16 = model_step(m16, 16, 1'b0);
            check($sformatf("zrun%0d_lfsr", c), 32'(lfsr16), m16);
            check($sformatf("zrun%0d_nonzero", c), 32'(lfsr16 != 16'h0), 32'h1);
            check($sformatf("zrun%0d_lock", c), 32'(lock16), 32'h0);
        end
        en16 = 1'b0;

        // Asynchronous reset mid-sequence, between edges
        reset = 1'b1;
        tick();
        reset = 1'b0; en16 = 1'b1;
        m16 = 32'h1;
        repeat (7) begin
            tick();
            m16 = model_step(m16, 16, 1'b0);
        end
        check("pre_areset_lfsr", 32'(lfsr16), m16);
        #2 reset = 1'b1;
        #1;
        check("areset_lfsr", 32'(lfsr16), 32'h1);
        check("areset_wrap", 32'(wrap16), 32'h0);
        check("areset_lock", 32'(lock16), 32'h0);
        ld16 = 1'b1; sd16 = 16'h1234;
        tick();
        check("reset_ignores_inputs", 32'(lfsr16), 32'h1);
        reset = 1'b0; ld16 = 1'b0;
        tick();
        check("first_step_after_reset", 32'(lfsr16), 32'h2);
        en16 = 1'b0;

        // Asynchronous reset discards a pending wrap pulse
        en4 = 1'b1;
        repeat (15) tick();
        check("w4_wrap_before_reset", 32'(wrap4), 32'h1);
        en4 = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("w4_wrap_killed", 32'(wrap4), 32'h0);
        check("w4_lfsr_reset", 32'(lfsr4), 32'h1);
        tick();
        reset = 1'b0;

        // Randomized traffic against the period-counting model
        m16 = 32'h1; c16 = 0; m4 = 32'h1; c4 = 0;
        for (int n = 0; n < 400; n++) begin
            r_ld16 = ($urandom_range(0, 7) == 0);
            r_en16 = 1'($urandom_range(0, 1));
            r_sd16 = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            r_ld4  = ($urandom_range(0, 7) == 0);
            r_en4  = ($urandom_range(0, 3) != 0);
            r_sd4  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            ld16 = r_ld16; en16 = r_en16; sd16 = r_sd16;
            ld4  = r_ld4;  en4  = r_en4;  sd4  = r_sd4;

            ew16 = 1'b0; el16 = 1'b0;
            if (r_ld16) begin
                m16 = (r_sd16 != 16'h0) ? 32'(r_sd16) : 32'h1;
                el16 = (r_sd16 == 16'h0);
                c16 = 0;
            end else if (r_en16) begin
                m16 = model_step(m16, 16, 1'b0);
                c16++;
                ew16 = ((c16 % 65535) == 0);
            end
            ew4 = 1'b0; el4 = 1'b0;
            if (r_ld4) begin
                m4 = (r_sd4 != 4'h0) ? 32'(r_sd4) : 32'h1;
                el4 = (r_sd4 == 4'h0);
                c4 = 0;
            end else if (r_en4) begin
                m4 = model_step(m4, 4, 1'b0);
                c4++;
                ew4 = ((c4 % 15) == 0);
            end

            tick();
            check($sformatf("rnd%0d_lfsr16", n), 32'(lfsr16), m16);
            check($sformatf("rnd%0d_wrap16", n), 32'(wrap16), 32'(ew16));
            check($sformatf("rnd%0d_lock16", n), 32'(lock16), 32'(el16));
            check($sformatf("rnd%0d_lfsr4", n), 32'(lfsr4), m4);
            check($sformatf("rnd%0d_wrap4", n), 32'(wrap4), 32'(ew4));
            check($sformatf("rnd%0d_lock4", n), 32'(lock4), 32'(el4));

            if ($urandom_range(0, 31) == 0) begin
                #2 reset = 1'b1;
                #1;
                check($sformatf("rnd%0d_rst_lfsr16", n), 32'(lfsr16), 32'h1);
                check($sformatf("rnd%0d_rst_lfsr4", n), 32'(lfsr4), 32'h1);
                check($sformatf("rnd%0d_rst_wrap4", n), 32'(wrap4), 32'h0);
                check($sformatf("rnd%0d_rst_lock4", n), 32'(lock4), 32'h0);
                reset = 1'b0;
                m16 = 32'h1; c16 = 0; m4 = 32'h1; c4 = 0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lfsr_gen.md
LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 Parameter WIDTH, default 16, register width in bits; legal range 3..32.
REQ-002 Parameter MODE, default 0, feedback form: 0 = Fibonacci (external XOR), 1 = Galois (internal XOR).
REQ-003 Parameter SEED, default 1, reset and recovery value; a zero SEED is an elaboration error.
REQ-004 Port clk  input  1  single clock; all state changes on rising edge.
REQ-005 Port reset  input  1  reset, asynchronous, active-high.
REQ-006 Port enable  input  1  advance one LFSR step per cycle while high.
REQ-007 Port load  input  1  load seed_in on the next rising edge; takes priority over enable.
REQ-008 Port seed_in  input  WIDTH  value to load.
REQ-009 Port lfsr  output  WIDTH  registered LFSR state.
REQ-010 Port bit_out  output  1  serial output, equal to lfsr[WIDTH-1].
REQ-011 Port wrap  output  1  registered one-cycle pulse marking completion of one full period.
REQ-012 Port lockup  output  1  registered one-cycle pulse marking a rejected all-zero load.

Function
REQ-013 Tap masks SHALL be maximal-length per WIDTH, from the package table; 16-bit Fibonacci mask = 0xD008 (taps 16,15,13,4); 4-bit mask = 0xC.
REQ-014 Fibonacci step SHALL be: fb = XOR-reduce(lfsr AND mask); next = {lfsr[WIDTH-2:0], fb}.
REQ-015 Galois step SHALL be: next = {lfsr[WIDTH-2:0], 0} XOR (lfsr[WIDTH-1] ? galois_mask : 0), with galois_mask taken from the package.
REQ-016 Either mode SHALL cycle through 2^WIDTH-1 distinct nonzero states.
REQ-017 Priority per edge SHALL be: load > enable > hold.
REQ-018 Load with seed_in != 0: lfsr <= seed_in, internal ref register <= seed_in, wrap <= 0, lockup <= 0.
REQ-019 Load with seed_in == 0: lfsr <= SEED, ref <= SEED, lockup <= 1 for exactly one cycle; the all-zero state SHALL never be reached.
REQ-020 Enable without load: lfsr <= next; wrap <= 1 iff next == ref, else 0.
REQ-021 Wrap SHALL therefore be high in the same cycle lfsr first shows ref again, i.e. on the (2^WIDTH-1)th enabled step after reset or load.
REQ-022 Hold (load and enable both low): lfsr and ref SHALL be unchanged; wrap and lockup SHALL be 0.
REQ-023 Step latency SHALL be one cycle from enable-high edge to updated lfsr; no combinational path from inputs to outputs except bit_out from lfsr.
REQ-024 Enable deasserted mid-sequence SHALL freeze state; resumption SHALL continue the sequence without a skipped state.

Reset
REQ-025 Assertion of reset SHALL immediately force lfsr = SEED, ref = SEED, wrap = 0, lockup = 0, independent of clk.
REQ-026 While reset is high, load and enable SHALL be ignored.
REQ-027 After reset deasserts, the first enabled edge SHALL produce step(SEED).
REQ-028 Reset asserted mid-sequence SHALL discard the sequence position and any pending pulse.

Structure
REQ-029 Package lfsr_pkg SHALL hold the Fibonacci and Galois tap-mask tables indexed by width (3..32), MODE encoding constants, and a next-state function.
REQ-030 One sub-module, lfsr_next (combinational next-state, parametrised by WIDTH and MODE), SHALL be instantiated by lfsr_gen; all registers SHALL live in lfsr_gen.

Verification
REQ-031 WIDTH=16, MODE=0, SEED=1: reset, then 4 enabled cycles -> lfsr = 0x0002, 0x0004, 0x0008, 0x0011.
REQ-032 WIDTH=4, MODE=0, SEED=1: 15 enabled cycles -> lfsr sequence 2,4,9,3,6,D,A,5,B,7,F,E,C,8,1 with wrap high only on the 15th cycle; then enable low -> lfsr stays 0x1, wrap 0.
REQ-033 WIDTH=16: load=1 and enable=1 together with seed_in=0xACE1 -> lfsr = 0xACE1, no step applied; next enabled cycle -> 0x59C3.
REQ-034 WIDTH=16: load=1 with seed_in=0x0000 -> lfsr = 0x0001 and lockup high for one cycle; lfsr never equals 0 in the following 100 enabled cycles.
REQ-035 WIDTH=16: reset asserted between clock edges after 7 steps -> lfsr = 0x0001 before the next rising edge; wrap = 0 and lockup = 0.
REQ-036 WIDTH=8, MODE=1, SEED=1, then WIDTH=8, MODE=0, SEED=1: 255 enabled cycles each -> 255 distinct nonzero states, with wrap pulsing exactly once, on cycle 255.
